// File: rtl/mxv_loader.sv
// Byte-stream loader for a matrix-vector unit: header N, N vector bytes, N*N matrix bytes.
// Optional idle timeout during loading is enabled by defining MXV_LOADER_TIMEOUT_EN.
module mxv_loader #(
    parameter int DW      = 8,
    parameter int NMAX    = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready,
    input  logic          done,
    output logic          wr_vec,
    output logic          wr_mat,
    output logic [2:0]    wr_sel,
    output logic [DW-1:0] wr_data,
    output logic [7:0]    N,
    output logic          start,
    output logic          busy,
    output logic          err
);

    // state       | meaning
    // S_IDLE      | waiting for header byte N
    // S_LOAD_VEC  | receiving N vector bytes
    // S_LOAD_MAT  | receiving N*N matrix bytes, row-major
    // S_START     | first cycle of start
    // S_WAIT_DONE | start held until done
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_VEC,
        S_LOAD_MAT,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      col, row, col_nxt, row_nxt, n_nxt;
    logic            wr_vec_nxt, wr_mat_nxt, err_nxt;
    logic [2:0]      sel_nxt;
    logic [DW-1:0]   data_nxt;
    logic            xfer;
    logic [31:0]     hdr;
    logic            last_col;

    assign rx_ready = (state == S_IDLE) || (state == S_LOAD_VEC) || (state == S_LOAD_MAT);
    assign xfer     = rx_valid && rx_ready;
    assign hdr      = 32'(rx_data);
    assign last_col = (col == N - 8'd1);
    assign start    = (state == S_START) || (state == S_WAIT_DONE);
    assign busy     = (state != S_IDLE);

`ifdef MXV_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt, tmo_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        row_nxt    = row;
        n_nxt      = N;
        wr_vec_nxt = 1'b0;
        wr_mat_nxt = 1'b0;
        err_nxt    = 1'b0;
        sel_nxt    = wr_sel;
        data_nxt   = wr_data;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (hdr >= 32'd1 && hdr <= 32'(NMAX)) begin
                        n_nxt     = 8'(rx_data);
                        col_nxt   = 8'd0;
                        row_nxt   = 8'd0;
                        state_nxt = S_LOAD_VEC;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD_VEC: begin
                if (xfer) begin
                    wr_vec_nxt = 1'b1;
                    sel_nxt    = col[2:0];
                    data_nxt   = rx_data;
                    if (last_col) begin
                        col_nxt   = 8'd0;
                        state_nxt = S_LOAD_MAT;
                    end else begin
                        col_nxt = col + 8'd1;
                    end
                end
            end
            S_LOAD_MAT: begin
                if (xfer) begin
                    wr_mat_nxt = 1'b1;
                    sel_nxt    = row[2:0];
                    data_nxt   = rx_data;
                    if (last_col) begin
                        col_nxt = 8'd0;
                        if (row == N - 8'd1) begin
                            row_nxt   = 8'd0;
                            state_nxt = S_START;
                        end else begin
                            row_nxt = row + 8'd1;
                        end
                    end else begin
                        col_nxt = col + 8'd1;
                    end
                end
            end
            S_START:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
`ifdef MXV_LOADER_TIMEOUT_EN
        tmo_nxt = '0;
        if ((state == S_LOAD_VEC || state == S_LOAD_MAT) && !xfer) begin
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                // Abandon the partial load; the next byte is treated as a fresh header.
                state_nxt = S_IDLE;
                err_nxt   = 1'b1;
                col_nxt   = 8'd0;
                row_nxt   = 8'd0;
            end else begin
                tmo_nxt = tmo_cnt + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            col     <= 8'd0;
            row     <= 8'd0;
            N       <= 8'd0;
            wr_vec  <= 1'b0;
            wr_mat  <= 1'b0;
            wr_sel  <= 3'd0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            col     <= col_nxt;
            row     <= row_nxt;
            N       <= n_nxt;
            wr_vec  <= wr_vec_nxt;
            wr_mat  <= wr_mat_nxt;
            wr_sel  <= sel_nxt;
            wr_data <= data_nxt;
            err     <= err_nxt;
        end
    end

`ifdef MXV_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) tmo_cnt <= '0;
        else       tmo_cnt <= tmo_nxt;
    end
`endif

endmodule

// File: tb/tb_mxv_loader.sv
// Self-checking bench for mxv_loader: randomized streams against a stream-format reference model.
module tb_mxv_loader;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset, rx_valid, rx_ready, done;
    logic [7:0] rx_data, wr_data, N;
    logic       wr_vec, wr_mat, start, busy, err;
    logic [2:0] wr_sel;

    always #5 clk = ~clk;

    mxv_loader #(.DW(8), .NMAX(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .done(done), .wr_vec(wr_vec), .wr_mat(wr_mat),
        .wr_sel(wr_sel), .wr_data(wr_data), .N(N), .start(start),
        .busy(busy), .err(err)
    );

    int n_cmp = 0, n_bad = 0;
    int obs[$];
    int cyc = 0, last_wr_cyc = 0, start_rise_cyc = 0;
    int err_cnt = 0, both_cnt = 0, busy_cyc = 0;
    bit start_q = 1'b0;

    // Observed writes encoded as kind<<16 | sel<<8 | data (kind 0 = vector, 1 = matrix).
    function automatic int enc(input int kind, input int sel, input int data);
        return (kind << 16) | (sel << 8) | data;
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (wr_vec || wr_mat) begin
            obs.push_back(enc(wr_mat ? 1 : 0, int'(wr_sel), int'(wr_data)));
            last_wr_cyc = cyc;
        end
        if (wr_vec && wr_mat) both_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cyc++;
        if (start && !start_q) start_rise_cyc = cyc;
        start_q = start;
    end

    task automatic push_byte(input logic [7:0] b, input int max_gap);
        int gap, t;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL push_wait rx_ready=%0b required 1", rx_ready);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Sends a complete stream (bytes[0] is N) and checks every write, N, start and the done handshake.
    task automatic run_stream(input bq_t bytes, input int max_gap, input string tag);
        int n, exp_q[$], nv, nm;
        n = int'(bytes[0]);
        for (int i = 0; i < n; i++) exp_q.push_back(enc(0, i, int'(bytes[1 + i])));
        for (int k = 0; k < n * n; k++) exp_q.push_back(enc(1, k / n, int'(bytes[1 + n + k])));
        obs.delete();
        foreach (bytes[i]) push_byte(bytes[i], max_gap);
        idle(1);
        n_cmp++;
        if (obs.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s write_count got %0d required %0d", tag, obs.size(), exp_q.size());
        end
        nv = 0; nm = 0;
        foreach (obs[i]) if (obs[i] >= 65536) nm++; else nv++;
        n_cmp++;
        if (nv !== n || nm !== n * n) begin
            n_bad++;
            $display("FAIL %s vec_mat_counts got %0d/%0d required %0d/%0d", tag, nv, nm, n, n * n);
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s write[%0d] got %h required %h", tag, i, obs[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (N !== 8'(n)) begin
            n_bad++;
            $display("FAIL %s N got %0d required %0d", tag, N, n);
        end
        n_cmp++;
        if (start !== 1'b1 || busy !== 1'b1 || start_rise_cyc < last_wr_cyc) begin
            n_bad++;
            $display("FAIL %s start_after_load got start=%0b busy=%0b rise=%0d lastwr=%0d required 1 1 rise>=lastwr",
                     tag, start, busy, start_rise_cyc, last_wr_cyc);
        end
        idle(1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_release got start=%0b busy=%0b required 0 0", tag, start, busy);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({rx_ready, busy, start, err, wr_vec, wr_mat} !== 6'b100000 || N !== 8'd0 || wr_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state got rdy/busy/start/err/vec/mat=%b N=%0d data=%0d required 100000 0 0",
                     {rx_ready, busy, start, err, wr_vec, wr_mat}, N, wr_data);
        end
    endtask

    task automatic test_directed();
        bq_t s;
        s = '{8'h02, 8'h05, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(s, 0, "directed_n2");
    endtask

    task automatic test_bad_header();
        int e0, b0;
        e0 = err_cnt; b0 = busy_cyc;
        obs.delete();
        push_byte(8'h00, 0);
        push_byte(8'h09, 0);
        idle(3);
        n_cmp++;
        if (err_cnt - e0 !== 2) begin
            n_bad++;
            $display("FAIL bad_header err_pulses got %0d required 2", err_cnt - e0);
        end
        n_cmp++;
        if (busy_cyc - b0 !== 0 || obs.size() !== 0) begin
            n_bad++;
            $display("FAIL bad_header busy_cycles=%0d writes=%0d required 0 0", busy_cyc - b0, obs.size());
        end
    endtask

    task automatic test_random_streams();
        bq_t s;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (r == 0) ? 8 : int'($urandom_range(1, 8));
            s.delete();
            s.push_back(8'(n));
            for (int i = 0; i < n + n * n; i++) s.push_back(8'($urandom));
            run_stream(s, (r == 0) ? 4 : 2, $sformatf("random_n%0d", n));
        end
    endtask

    task automatic test_reset_midload();
        bq_t s;
        push_byte(8'h03, 0);
        for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i), 0);
        @(negedge clk);
        obs.delete();
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(negedge clk);
        n_cmp++;
        if ({wr_vec, wr_mat, start, busy, err} !== 5'b0 || N !== 8'd0 || wr_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_midload got vec/mat/start/busy/err=%b N=%0d data=%0d required 00000 0 0",
                     {wr_vec, wr_mat, start, busy, err}, N, wr_data);
        end
        reset    = 1'b0;
        rx_valid = 1'b0;
        idle(1);
        n_cmp++;
        if (obs.size() !== 0) begin
            n_bad++;
            $display("FAIL reset_midload writes got %0d required 0", obs.size());
        end
        s = '{8'h01, 8'h5A, 8'hC3};
        run_stream(s, 0, "after_reset_n1");
    endtask

    task automatic test_wait_done();
        int w0;
        idle(1);
        done = 1'b1;
        idle(3);
        done = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            n_bad++;
            $display("FAIL done_in_idle got busy=%0b start=%0b required 0 0", busy, start);
        end
        obs.delete();
        push_byte(8'h01, 0);
        idle(1);
        done = 1'b1;
        idle(2);
        done = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || start !== 1'b0 || rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL done_in_load got busy=%0b start=%0b rdy=%0b required 1 0 1", busy, start, rx_ready);
        end
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        idle(2);
        w0 = obs.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            n_cmp++;
            if (rx_ready !== 1'b0 || start !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL wait_done_hold got rdy=%0b start=%0b busy=%0b required 0 1 1", rx_ready, start, busy);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (obs.size() !== w0 || w0 !== 2) begin
            n_bad++;
            $display("FAIL wait_done_writes got %0d/%0d required 2/2", w0, obs.size());
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_cmp++;
        if (start !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_done_release got start=%0b busy=%0b required 0 0", start, busy);
        end
    endtask

`ifdef MXV_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        bq_t s;
        int e0;
        e0 = err_cnt;
        obs.delete();
        push_byte(8'h02, 0);
        push_byte(8'h01, 0);
        push_byte(8'h02, 0);
        push_byte(8'h03, 0);
        push_byte(8'h04, 15);
        push_byte(8'h05, 0);
        push_byte(8'h06, 0);
        idle(1);
        n_cmp++;
        if (err_cnt !== e0 || start !== 1'b1 || obs.size() !== 6) begin
            n_bad++;
            $display("FAIL stall15 got errs=%0d start=%0b writes=%0d required 0 1 6", err_cnt - e0, start, obs.size());
        end
        idle(1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        push_byte(8'h02, 0);
        push_byte(8'h01, 0);
        push_byte(8'h02, 0);
        push_byte(8'h03, 0);
        idle(16);
        n_cmp++;
        if (err_cnt - e0 !== 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall16_early got errs=%0d busy=%0b required 0 1", err_cnt - e0, busy);
        end
        idle(2);
        n_cmp++;
        if (err_cnt - e0 !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stall16 got errs=%0d busy=%0b required 1 0", err_cnt - e0, busy);
        end
        s = '{8'h01, 8'h77, 8'h88};
        run_stream(s, 0, "after_timeout_n1");
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog sim time exceeded, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_bad_header();
        test_random_streams();
        test_reset_midload();
        test_wait_done();
`ifdef MXV_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL vec_mat_overlap got %0d cycles required 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
